// File: rtl/ioport2_msg_regport.sv
// ioport2_msg_regport
//   Register-access engine between the IoPort2 message decoder and encoder.
//   Takes 64-bit request messages, performs one single-beat write and/or read
//   on a strobe/ack register port, and returns read completions as 64-bit
//   messages. One transaction in flight at a time; reads are guarded by a
//   timeout that synthesizes TIMEOUT_DATA, and dropped messages / timeouts are
//   tallied in a saturating error counter.
//
//   Request message : [63] completion flag, [62] write, [61] read, [60] half,
//                     [59:52] reserved, [51:32] address, [31:0] data
//   Completion      : {1'b1, 31'h0, data}
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   in_tdata/in_tvalid/in_tready    request stream
//   out_tdata/out_tvalid/out_tready completion stream
//   set_stb/set_addr/set_data/set_half   write port (one-cycle strobe)
//   rb_stb/rb_addr/rb_half/rb_ack/rb_data read port (one-cycle strobe, ack)
//   err_count                       saturating dropped-message/timeout count
module ioport2_msg_regport #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [63:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        set_stb,
  output logic [19:0] set_addr,
  output logic [31:0] set_data,
  output logic        set_half,
  output logic        rb_stb,
  output logic [19:0] rb_addr,
  output logic        rb_half,
  input  logic        rb_ack,
  input  logic [31:0] rb_data,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  // Wait counter runs 0..TIMEOUT-1; the last value is the timeout decision.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t state, state_next;

  logic          alive;     // low only while in reset; keeps in_tready at 0 then
  logic          req_rd;
  logic          req_half;
  logic [19:0]   req_addr;
  logic [31:0]   req_data;
  logic [CW-1:0] cnt;

  logic accept;
  logic cnt_clr, cnt_inc, cap_ack, cap_to, err_inc;

  // Reserved request bits are deliberately ignored.
  logic unused_reserved;
  assign unused_reserved = ^in_tdata[59:52];

  assign in_tready  = alive && (state == IDLE);
  assign accept     = in_tvalid && in_tready;

  assign set_stb    = (state == WRITE);
  assign rb_stb     = (state == READ);
  assign out_tvalid = (state == RESP);

  assign set_addr   = req_addr;
  assign rb_addr    = req_addr;
  assign set_half   = req_half;
  assign rb_half    = req_half;
  assign set_data   = req_half ? {16'h0, req_data[15:0]} : req_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_next;
      alive <= 1'b1;
    end
  end

  // NOTE: every signal this block drives gets a default before the case, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cap_ack    = 1'b0;
    cap_to     = 1'b0;
    err_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (in_tdata[63])      err_inc    = 1'b1;   // inbound completion: drop
          else if (in_tdata[62]) state_next = WRITE;
          else if (in_tdata[61]) state_next = READ;
        end
      end
      WRITE: state_next = req_rd ? READ : IDLE;       // read-after-write
      READ: begin
        cnt_clr = 1'b1;
        if (rb_ack) begin
          cap_ack    = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (rb_ack) begin
          cap_ack    = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          cap_to     = 1'b1;
          err_inc    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: if (out_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_rd    <= 1'b0;
      req_half  <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      cnt       <= '0;
      out_tdata <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        req_rd   <= in_tdata[61];
        req_half <= in_tdata[60];
        req_addr <= in_tdata[51:32];
        req_data <= in_tdata[31:0];
      end

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (cap_ack)
        out_tdata <= {1'b1, 31'h0, (req_half ? {16'h0, rb_data[15:0]} : rb_data)};
      else if (cap_to)
        out_tdata <= {1'b1, 31'h0, TIMEOUT_DATA};

      if (err_inc && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ioport2_msg_regport.sv
// Self-checking bench for ioport2_msg_regport (TIMEOUT = 4).
// Stimulus pushes hand-computed expectations (write strobes, read strobes,
// completions, each with its expected cycle) into queues; a negedge monitor
// pops and compares whenever the DUT presents a strobe or a completion.
module tb_ioport2_msg_regport;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic [63:0] out_tdata;
  logic        out_tvalid;
  logic        out_rdy;
  logic        set_stb;
  logic [19:0] set_addr;
  logic [31:0] set_data;
  logic        set_half;
  logic        rb_stb;
  logic [19:0] rb_addr;
  logic        rb_half;
  logic        rb_ack = 1'b0;
  logic [31:0] rb_data = 32'h0;
  logic [15:0] err_count;

  ioport2_msg_regport #(.TIMEOUT(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_rdy),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data), .set_half(set_half),
    .rb_stb(rb_stb), .rb_addr(rb_addr), .rb_half(rb_half),
    .rb_ack(rb_ack), .rb_data(rb_data),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct { logic [19:0] addr; logic [31:0] data; logic half; int cy; } wexp_t;
  typedef struct { logic [19:0] addr; logic half; int cy; } rexp_t;
  typedef struct { logic [63:0] data; int cy; } cexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  cexp_t cq[$];

  // Register-port responder: acks ack_delay cycles after rb_stb (0 = same
  // cycle, -1 = never). extra_ack injects a stray ack; it is changed only
  // just after a posedge so this negedge process sees a settled value.
  int          ack_delay = -1;
  int          acnt = -1;
  logic        extra_ack = 1'b0;
  logic [31:0] rb_data_v = 32'h0;

  always @(negedge clk) begin
    if (!reset_n)    acnt = -1;
    else if (rb_stb) acnt = ack_delay;
    rb_ack  = (acnt == 0) || extra_ack;
    if (acnt >= 0) acnt--;
    rb_data = rb_data_v;
  end

  // Monitor
  logic        prev_v = 1'b0;
  int          vstart = 0;
  logic [63:0] vdata = '0;
  wexp_t       we;
  rexp_t       re;
  cexp_t       ce;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (set_stb) begin
        if (wq.size() == 0) fail_now("unexpected set_stb");
        else begin
          we = wq.pop_front();
          check("set_addr", 64'(set_addr), 64'(we.addr));
          check("set_data", 64'(set_data), 64'(we.data));
          check("set_half", 64'(set_half), 64'(we.half));
          check("set_stb cycle", 64'(cyc), 64'(we.cy));
        end
      end
      if (rb_stb) begin
        if (rq.size() == 0) fail_now("unexpected rb_stb");
        else begin
          re = rq.pop_front();
          check("rb_addr", 64'(rb_addr), 64'(re.addr));
          check("rb_half", 64'(rb_half), 64'(re.half));
          check("rb_stb cycle", 64'(cyc), 64'(re.cy));
        end
      end
      if (out_tvalid) begin
        if (!prev_v) begin
          vstart = cyc;
          vdata  = out_tdata;
        end else begin
          check("out_tdata stable", out_tdata, vdata);
        end
        if (out_rdy) begin
          if (cq.size() == 0) fail_now("unexpected completion");
          else begin
            ce = cq.pop_front();
            check("completion data", out_tdata, ce.data);
            check("out_tvalid cycle", 64'(vstart), 64'(ce.cy));
          end
        end
      end
      prev_v = out_tvalid && !out_rdy;
    end
  end

  // Present a request and push the hand-computed expectations, with cycle
  // offsets relative to the handshake cycle N. Returns at cycle N+1.
  task automatic send(input logic [63:0] d,
                      input bit dw, input logic [19:0] wa, input logic [31:0] wd,
                      input logic wh, input int wo,
                      input bit dr, input logic [19:0] ra, input logic rh, input int ro,
                      input bit dc, input logic [63:0] cd, input int co);
    int n;
    bit got;
    got = 1'b0;
    in_tdata  = d;
    in_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_tready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      fail_now("in_tready wait timeout");
      in_tvalid = 1'b0;
      return;
    end
    n = cyc;
    if (dw) wq.push_back('{wa, wd, wh, n + wo});
    if (dr) rq.push_back('{ra, rh, n + ro});
    if (dc) cq.push_back('{cd, n + co});
    @(negedge clk);
    in_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wq.size() == 0 && rq.size() == 0 && cq.size() == 0 && in_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("transaction did not complete");
      wq.delete();
      rq.delete();
      cq.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 64'({in_tready, out_tvalid, set_stb, rb_stb, set_half, rb_half}), 64'h0);
    check({tag, " err_count"}, 64'(err_count), 64'h0);
    check({tag, " out_tdata"}, out_tdata, 64'h0);
    check({tag, " addrs"}, 64'({set_addr, rb_addr}), 64'h0);
    check({tag, " set_data"}, 64'(set_data), 64'h0);
  endtask

  initial begin
    in_tvalid = 1'b0;
    in_tdata  = '0;
    out_rdy   = 1'b1;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("in_tready after reset", 64'(in_tready), 64'h1);

    // 32-bit write
    send(64'h4000_0123_CAFE_F00D, 1, 20'h00123, 32'hCAFE_F00D, 1'b0, 1,
         0, 20'h0, 1'b0, 0, 0, 64'h0, 0);
    check("in_tready N+1 write", 64'(in_tready), 64'h0);
    @(negedge clk);
    check("in_tready N+2 write", 64'(in_tready), 64'h1);

    // half-word write: upper data bits zeroed
    send(64'h5000_0042_ABCD_1234, 1, 20'h00042, 32'h0000_1234, 1'b1, 1,
         0, 20'h0, 1'b0, 0, 0, 64'h0, 0);
    wait_idle();

    // half-word read, ack 3 cycles after strobe
    ack_delay = 3;
    rb_data_v = 32'h1234_5678;
    send(64'h300A_BCDE_0000_0000, 0, 20'h0, 32'h0, 1'b0, 0,
         1, 20'hABCDE, 1'b1, 1, 1, 64'h8000_0000_0000_5678, 5);
    wait_idle();

    // full read, ack in the strobe cycle
    ack_delay = 0;
    rb_data_v = 32'hA5A5_5A5A;
    send(64'h2000_0777_0000_0000, 0, 20'h0, 32'h0, 1'b0, 0,
         1, 20'h00777, 1'b0, 1, 1, 64'h8000_0000_A5A5_5A5A, 2);
    wait_idle();

    // ack on the last allowed cycle (k = TIMEOUT) beats the timeout
    ack_delay = TO;
    rb_data_v = 32'h0102_0304;
    send(64'h2000_0888_0000_0000, 0, 20'h0, 32'h0, 1'b0, 0,
         1, 20'h00888, 1'b0, 1, 1, 64'h8000_0000_0102_0304, 6);
    wait_idle();
    check("err_count after k=TIMEOUT", 64'(err_count), 64'h0);

    // read timeout
    ack_delay = -1;
    send(64'h2001_2345_0000_0000, 0, 20'h0, 32'h0, 1'b0, 0,
         1, 20'h12345, 1'b0, 1, 1, 64'h8000_0000_DEAD_BEEF, 6);
    wait_idle();
    check("err_count after timeout", 64'(err_count), 64'h1);

    // late ack while idle must be ignored
    @(posedge clk); #1 extra_ack = 1'b1;
    @(posedge clk); #1 extra_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("late ack out_tvalid", 64'(out_tvalid), 64'h0);
    check("late ack err_count", 64'(err_count), 64'h1);

    // inbound completion: dropped and counted
    send(64'h8000_0000_0000_0001, 0, 20'h0, 32'h0, 1'b0, 0,
         0, 20'h0, 1'b0, 0, 0, 64'h0, 0);
    check("drop in_tready", 64'(in_tready), 64'h1);
    check("drop err_count", 64'(err_count), 64'h2);

    // null request: consumed silently
    send(64'h0FF1_2345_6789_ABCD, 0, 20'h0, 32'h0, 1'b0, 0,
         0, 20'h0, 1'b0, 0, 0, 64'h0, 0);
    check("null in_tready", 64'(in_tready), 64'h1);
    check("null err_count", 64'(err_count), 64'h2);

    // read-after-write with completion backpressure
    @(posedge clk); #1 out_rdy = 1'b0;
    @(negedge clk);
    ack_delay = 0;
    rb_data_v = 32'h0BAD_F00D;
    send(64'h6000_0055_0000_1111, 1, 20'h00055, 32'h0000_1111, 1'b0, 1,
         1, 20'h00055, 1'b0, 2, 1, 64'h8000_0000_0BAD_F00D, 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("stall in_tready", 64'(in_tready), 64'h0);
      check("stall out_tvalid", 64'(out_tvalid), 64'(i >= 1));
    end
    @(posedge clk); #1 out_rdy = 1'b1;
    @(negedge clk);
    check("in_tready at handshake", 64'(in_tready), 64'h0);
    @(negedge clk);
    check("in_tready after handshake", 64'(in_tready), 64'h1);
    wait_idle();

    // reset asserted while waiting for an ack
    ack_delay = -1;
    send(64'h2000_0999_0000_0000, 0, 20'h0, 32'h0, 1'b0, 0,
         1, 20'h00999, 1'b0, 1, 0, 64'h0, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid-op reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_tready after re-reset", 64'(in_tready), 64'h1);
    send(64'h4000_0ABC_1357_9BDF, 1, 20'h00ABC, 32'h1357_9BDF, 1'b0, 1,
         0, 20'h0, 1'b0, 0, 0, 64'h0, 0);
    wait_idle();
    check("no completion after abort", 64'(cq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ioport2_msg_regport.md
# ioport2_msg_regport

Register-access engine that sits directly downstream of the IoPort2 message decoder and upstream of the message encoder. It consumes 64-bit transaction-request messages from a valid/ready stream, performs single-beat writes and reads on a strobe/ack register port, and returns read completions as 64-bit messages on an outbound stream. It processes one transaction at a time, with a read-timeout guard and a saturating error counter.

## Interface
- TIMEOUT, 255: cycles to wait for `rb_ack` after `rb_stb` before synthesizing a completion; must be ≥1.
- TIMEOUT_DATA, 32'hDEAD_BEEF: completion data returned on a read timeout.
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- in_tdata  in  64  request message.
- in_tvalid  in  1  request valid.
- in_tready  out  1  request accept.
- out_tdata  out  64  completion message.
- out_tvalid  out  1  completion valid.
- out_tready  in  1  completion accept.
- set_stb  out  1  one-cycle write strobe.
- set_addr  out  20  write address.
- set_data  out  32  write data; upper 16 bits zeroed when `set_half`=1.
- set_half  out  1  16-bit write qualifier.
- rb_stb  out  1  one-cycle read strobe.
- rb_addr  out  20  read address.
- rb_half  out  1  16-bit read qualifier.
- rb_ack  in  1  read data valid.
- rb_data  in  32  read data.
- err_count  out  16  saturating count of dropped messages and read timeouts.

## Operation
- Request fields: [63] completion flag, [62] write, [61] read, [60] half word, [59:52] reserved (ignored), [51:32] address, [31:0] data.
- Completion output: {1'b1, 31'h0, data}; data is `rb_data` (for half reads, `{16'h0, rb_data[15:0]}`) or TIMEOUT_DATA.
- FSM states: IDLE, WRITE, READ, WAIT, RESP.
- **IDLE:** `in_tready`=1. The request is latched on handshake. Next state:
  - [63]=1 → drop (increment `err_count`), stay IDLE.
  - [62]=1 → WRITE.
  - else [61]=1 → READ.
  - else → consume silently, stay IDLE.
- **WRITE:** `set_stb`=1 for exactly one cycle, with `set_addr`, `set_data`, and `set_half` valid that cycle. Next state is READ if [61] is also set (read-after-write), else IDLE.
- **READ:** `rb_stb`=1 for one cycle; the timeout counter is cleared. Next state is WAIT, or RESP directly if `rb_ack`=1 in that same cycle (data captured).
- **WAIT:** On `rb_ack`, capture data and go to RESP. If the counter reaches TIMEOUT with no ack, load TIMEOUT_DATA, increment `err_count`, and go to RESP. `rb_ack` is ignored in every state except READ and WAIT.
- **RESP:** `out_tvalid`=1 and `out_tdata` is held stable until `out_tready`. On handshake, go to IDLE.
- `err_count` saturates at 16'hFFFF.
- `set_addr`/`rb_addr` are held from the latched request; they are only valid during their strobe.

## Timing
- All outputs reset to 0: `in_tready`, `out_tvalid`, `out_tdata`, strobes, `set_addr`, `set_data`, `set_half`, `rb_addr`, `rb_half`, `err_count`. The FSM resets to IDLE.
- `in_tready` rises in the first cycle after `reset_n` deasserts.
- Write: request handshake at cycle N → `set_stb` at N+1 → `in_tready` high again at N+2.
- Read with ack in the strobe cycle: handshake at N → `rb_stb` at N+1 → `out_tvalid` at N+2.
- Ack k cycles after the strobe (1 ≤ k ≤ TIMEOUT): `out_tvalid` at N+2+k.
- Timeout: `out_tvalid` at N+2+TIMEOUT.
- `out_tready` held high: `in_tready` returns one cycle after the completion handshake.
- Read-after-write: `set_stb` at N+1, `rb_stb` at N+2.
- Backpressure on `out_tready` stalls the engine indefinitely; no second request is accepted while a transaction is in flight.
- `reset_n` assertion mid-operation immediately clears state and outputs:
  - any strobe or `out_tvalid` in progress drops asynchronously;
  - no completion is produced for the aborted request.

## Test plan
- **Write 32-bit:** in_tdata=64'h4000_0123_CAFE_F00D → one `set_stb` with addr 20'h00123, data 32'hCAFEF00D, half 0; no `out_tvalid`.
- **Half-word read, ack after 3 cycles:** addr 20'hABCDE, `rb_data`=32'h1234_5678 → `rb_stb`/`rb_half`=1; completion 64'h8000_0000_0000_5678 at N+5.
- **Read timeout (TIMEOUT=4), no ack:** completion 64'h8000_0000_DEAD_BEEF at N+6; `err_count`=1. A late `rb_ack` afterwards causes no output.
- **Inbound completion and null request:**
  - message with [63]=1 → consumed, `err_count`+1, no strobes;
  - message with [63:60]=0 → consumed, no strobes, no count change.
- **Read-after-write with out_tready low for 10 cycles:** `set_stb` at N+1, `rb_stb` at N+2; `out_tdata` stable while stalled; `in_tready` low until 1 cycle after the handshake.
- **reset_n asserted in WAIT:** all outputs 0 immediately. After release, a new write request completes with normal N+1 strobe timing.
